// File: rtl/trng_conditioner.sv
// Ring-oscillator TRNG consumer: run control, health tests,
// von Neumann debiasing and word packing with valid/ready output.
module trng_conditioner #(
  parameter int WORD_W     = 16,
  parameter int SAMPLE_DIV = 4,
  parameter int WARMUP_CYC = 64,
  parameter int REP_LIMIT  = 32,
  parameter int APT_WINDOW = 512,
  parameter int APT_LIMIT  = 410
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              raw_bit,
  output logic              trng_run,
  output logic [WORD_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              alarm,
  input  logic              clear_alarm
);

  localparam int WCW = $clog2(WARMUP_CYC + 1);
  localparam int DCW = $clog2(SAMPLE_DIV + 1);
  localparam int BCW = $clog2(WORD_W);
  localparam int RCW = $clog2(REP_LIMIT + 1);
  localparam int AIW = $clog2(APT_WINDOW);
  localparam int ACW = $clog2(APT_WINDOW + 1);

  localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_CYC - 1);
  localparam logic [DCW-1:0] DIV_LAST  = DCW'(SAMPLE_DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_W - 1);
  localparam logic [RCW-1:0] REP_MAX   = RCW'(REP_LIMIT);
  localparam logic [AIW-1:0] WIN_LAST  = AIW'(APT_WINDOW - 1);
  localparam logic [ACW-1:0] APT_MAX   = ACW'(APT_LIMIT);

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    COLLECT,
    HOLD,
    ALARM
  } state_t;

  state_t state;
  state_t state_next;

  logic [WCW-1:0]    warm_cnt;
  logic [DCW-1:0]    div_cnt;
  logic [BCW-1:0]    bit_cnt;
  logic [WORD_W-1:0] shreg;
  logic              pair_phase;
  logic              pair_a;

  logic [RCW-1:0] rep_cnt;
  logic           rep_last;
  logic [AIW-1:0] apt_idx;
  logic [ACW-1:0] apt_cnt;
  logic           apt_ref;

  logic           sampling;
  logic           strobe;
  logic           warm_done;
  logic [RCW-1:0] rep_next;
  logic [ACW-1:0] apt_next;
  logic           health_fail;
  logic           keep;
  logic           word_done;

  always_comb begin
    sampling  = (state == COLLECT) || (state == HOLD);
    strobe    = sampling && (div_cnt == DIV_LAST);
    warm_done = (warm_cnt == WARM_LAST);
    rep_next  = RCW'(1);
    if ((rep_cnt == '0) || (raw_bit == rep_last)) begin
      rep_next = (rep_cnt >= REP_MAX) ? rep_cnt
                                      : rep_cnt + RCW'(1);
    end
    // first sample of a window is its own reference
    if (apt_idx == '0) begin
      apt_next = ACW'(1);
    end else begin
      apt_next = apt_cnt + ACW'(raw_bit == apt_ref);
    end
    health_fail = strobe &&
                  ((rep_next >= REP_MAX) || (apt_next == APT_MAX));
    keep = strobe && (state == COLLECT) && pair_phase &&
           (pair_a != raw_bit);
    word_done = keep && (bit_cnt == BIT_LAST);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (enable) state_next = WARMUP;
      end
      WARMUP: begin
        if (!enable)        state_next = IDLE;
        else if (warm_done) state_next = COLLECT;
      end
      COLLECT: begin
        if (health_fail)    state_next = ALARM;
        else if (!enable)   state_next = IDLE;
        else if (word_done) state_next = HOLD;
      end
      HOLD: begin
        if (health_fail)    state_next = ALARM;
        else if (!enable)   state_next = IDLE;
        else if (ready)     state_next = COLLECT;
      end
      ALARM: begin
        if (clear_alarm) state_next = enable ? WARMUP : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // outputs are registered copies of the next-state decode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid    <= 1'b0;
      alarm    <= 1'b0;
      trng_run <= 1'b0;
      data     <= '0;
    end else begin
      valid    <= (state_next == HOLD);
      alarm    <= (state_next == ALARM);
      trng_run <= (state_next == WARMUP) ||
                  (state_next == COLLECT) ||
                  (state_next == HOLD);
      if ((state == COLLECT) && (state_next == HOLD)) begin
        data <= {shreg[WORD_W-2:0], pair_a};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      warm_cnt <= '0;
    end else if (state == WARMUP) begin
      warm_cnt <= warm_cnt + WCW'(1);
    end else begin
      warm_cnt <= '0;
    end
  end

  // free-runs through HOLD so strobe spacing is unbroken
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (!sampling || strobe) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DCW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_cnt  <= '0;
      rep_last <= 1'b0;
      apt_idx  <= '0;
      apt_cnt  <= '0;
      apt_ref  <= 1'b0;
    end else if (state == WARMUP) begin
      rep_cnt  <= '0;
      rep_last <= 1'b0;
      apt_idx  <= '0;
      apt_cnt  <= '0;
      apt_ref  <= 1'b0;
    end else if (strobe) begin
      rep_cnt  <= rep_next;
      rep_last <= raw_bit;
      apt_cnt  <= apt_next;
      if (apt_idx == '0) apt_ref <= raw_bit;
      apt_idx <= (apt_idx == WIN_LAST) ? '0
                                       : apt_idx + AIW'(1);
    end
  end

  // extractor only runs in COLLECT; any other state discards it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pair_phase <= 1'b0;
      pair_a     <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
    end else if (state != COLLECT) begin
      pair_phase <= 1'b0;
      pair_a     <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
    end else if (strobe) begin
      if (!pair_phase) begin
        pair_a     <= raw_bit;
        pair_phase <= 1'b1;
      end else begin
        pair_phase <= 1'b0;
      end
      if (keep) begin
        shreg   <= {shreg[WORD_W-2:0], pair_a};
        bit_cnt <= word_done ? '0 : bit_cnt + BCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_trng_conditioner.sv
// Directed bench for trng_conditioner: pattern table plus
// hand sequences for stall, alarm, APT and enable corners.
module tb_trng_conditioner;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        raw_bit;
  logic        trng_run;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic        alarm;
  logic        clear_alarm;

  int tests = 0;
  int fails = 0;

  trng_conditioner dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .raw_bit     (raw_bit),
    .trng_run    (trng_run),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .alarm       (alarm),
    .clear_alarm (clear_alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pat;
    int          len;
    int          nsamp;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_alarm;
    logic        exp_run;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic patbit(input logic [15:0] p,
                                  input int len,
                                  input int s);
    int k;
    k = len - 1 - (s % len);
    return p[k];
  endfunction

  // one sample period; strobe lands on the 4th edge
  task automatic step(input logic b);
    raw_bit = b;
    repeat (4) tick();
  endtask

  task automatic run_pat(input logic [15:0] p, input int len,
                         input int first, input int n);
    for (int s = first; s < first + n; s++) step(patbit(p, len, s));
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    enable      = 1'b0;
    ready       = 1'b0;
    clear_alarm = 1'b0;
    raw_bit     = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // enable edge plus 64 warmup cycles, ends at COLLECT entry
  task automatic start();
    enable = 1'b1;
    repeat (65) tick();
  endtask

  initial begin
    vecs[0] = '{16'h0002, 2, 32, 1'b1, 16'hFFFF, 1'b0, 1'b1};
    vecs[1] = '{16'h0001, 2, 32, 1'b1, 16'h0000, 1'b0, 1'b1};
    vecs[2] = '{16'h002D, 6, 48, 1'b1, 16'hAAAA, 1'b0, 1'b1};
    vecs[3] = '{16'h0006, 4, 32, 1'b1, 16'h5555, 1'b0, 1'b1};
    vecs[4] = '{16'h0002, 2, 31, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[5] = '{16'h000C, 4, 64, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[6] = '{16'h0001, 1, 31, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[7] = '{16'h0001, 1, 32, 1'b0, 16'h0000, 1'b1, 1'b0};

    reset       = 1'b0;
    enable      = 1'b0;
    ready       = 1'b0;
    clear_alarm = 1'b0;
    raw_bit     = 1'b0;
    #12;
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_run", trng_run, 0);
    tick();
    reset = 1'b1;
    tick();
    enable = 1'b1;
    chk("run_before", trng_run, 0);
    tick();
    chk("run_rise", trng_run, 1);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      start();
      run_pat(vecs[i].pat, vecs[i].len, 0, vecs[i].nsamp);
      chk($sformatf("v%0d_valid", i), valid, vecs[i].exp_valid);
      chk($sformatf("v%0d_data", i), data, vecs[i].exp_data);
      chk($sformatf("v%0d_alarm", i), alarm, vecs[i].exp_alarm);
      chk($sformatf("v%0d_run", i), trng_run, vecs[i].exp_run);
    end

    // HOLD stall, then a one-cycle ready pulse
    do_reset();
    start();
    run_pat(16'h0002, 2, 0, 57);
    chk("stall_valid", valid, 1);
    chk("stall_data", data, 16'hFFFF);
    raw_bit = 1'b0;
    ready   = 1'b1;
    tick();
    ready = 1'b0;
    chk("pulse_valid", valid, 0);
    repeat (3) tick();
    run_pat(16'h0001, 2, 1, 30);
    chk("next_early", valid, 0);
    run_pat(16'h0001, 2, 31, 1);
    chk("next_valid", valid, 1);
    chk("next_data", data, 16'h0000);

    // sticky alarm, enable ignored, then clear
    do_reset();
    start();
    run_pat(16'h0001, 1, 0, 32);
    chk("alm_set", alarm, 1);
    enable = 1'b0;
    repeat (5) tick();
    chk("alm_sticky", alarm, 1);
    chk("alm_run", trng_run, 0);
    enable      = 1'b1;
    clear_alarm = 1'b1;
    tick();
    clear_alarm = 1'b0;
    chk("clr_alarm", alarm, 0);
    chk("clr_run", trng_run, 1);
    repeat (64) tick();
    run_pat(16'h0002, 2, 0, 32);
    chk("clr_valid", valid, 1);
    chk("clr_data", data, 16'hFFFF);

    // fifteen 1s then a 0: only the APT trips, at sample 437
    do_reset();
    ready = 1'b1;
    start();
    run_pat(16'hFFFE, 16, 0, 436);
    chk("apt_436", alarm, 0);
    run_pat(16'hFFFE, 16, 436, 1);
    chk("apt_437", alarm, 1);
    chk("apt_run", trng_run, 0);
    chk("apt_valid", valid, 0);

    // enable dropped mid-word, then restart from scratch
    do_reset();
    start();
    run_pat(16'h0002, 2, 0, 20);
    enable = 1'b0;
    tick();
    chk("drop_run", trng_run, 0);
    chk("drop_valid", valid, 0);
    repeat (10) tick();
    chk("idle_run", trng_run, 0);
    enable = 1'b1;
    tick();
    chk("re_run", trng_run, 1);
    repeat (64) tick();
    run_pat(16'h0001, 2, 0, 31);
    chk("re_early", valid, 0);
    run_pat(16'h0001, 2, 31, 1);
    chk("re_valid", valid, 1);
    chk("re_data", data, 16'h0000);

    // asynchronous reset while a word is held
    do_reset();
    start();
    run_pat(16'h0002, 2, 0, 32);
    chk("pre_valid", valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_data", data, 0);
    chk("arst_run", trng_run, 0);
    tick();
    reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
